// File: rtl/float2fix_pipe.sv
// Pipelined IEEE-754 float to signed Q(FIX_INT_LEN).F fixed-point converter with RTZ/RNE rounding and saturation.
// Latency: 2 register stages (unpack/classify, then shift/round/saturate); one result per cycle under continuous ready.
// Backpressure: valid/ready; each stage advances when its successor is empty or draining; output held while stalled.
module float2fix_pipe #(
    parameter int E_LEN       = 8,
    parameter int M_LEN       = 23,
    parameter int FIX_LEN     = 64,
    parameter int FIX_INT_LEN = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [E_LEN+M_LEN:0]     float_i,
    input  logic                     rm_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [FIX_LEN-1:0]       fix_o,
    output logic [3:0]               flags_o
);

    localparam int F     = FIX_LEN - FIX_INT_LEN;
    localparam int BIAS  = (1 << (E_LEN - 1)) - 1;
    localparam int MAG_W = M_LEN + 1;
    localparam int EXT_W = 2 * MAG_W + 1;
    localparam int SH_W  = E_LEN + 3;
    localparam int RW    = FIX_LEN + 1;

    localparam logic [FIX_LEN-1:0] MAX_POS = {1'b0, {(FIX_LEN-1){1'b1}}};
    localparam logic [FIX_LEN-1:0] MAX_NEG = {1'b1, {(FIX_LEN-1){1'b0}}};
    localparam logic [RW-1:0]      NEG_LIM = RW'(1) << (FIX_LEN - 1);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_INF,
        CLS_NAN,
        CLS_NORM
    } cls_t;

    // handshake
    logic rdy_q;
    logic s1_valid;
    logic s1_advance;
    logic in_fire;

    assign s1_advance = s1_valid & (!out_valid_o | out_ready_i);
    assign in_ready_o = rdy_q & (!s1_valid | s1_advance);
    assign in_fire    = in_valid_i & in_ready_o;

    // stage 1: unpack and classify
    logic [E_LEN-1:0]         in_exp;
    logic [M_LEN-1:0]         in_man;
    cls_t                     in_cls;
    logic signed [SH_W-1:0]   in_sh;

    assign in_exp = float_i[E_LEN+M_LEN-1:M_LEN];
    assign in_man = float_i[M_LEN-1:0];
    assign in_sh  = SH_W'(int'(in_exp) - BIAS - M_LEN + F);

    always_comb begin
        in_cls = CLS_NORM;
        if (in_exp == '0) begin
            in_cls = (in_man == '0) ? CLS_ZERO : CLS_DENORM;
        end else if (&in_exp) begin
            in_cls = (in_man == '0) ? CLS_INF : CLS_NAN;
        end
    end

    logic                   s1_sign;
    cls_t                   s1_cls;
    logic [MAG_W-1:0]       s1_mag;
    logic signed [SH_W-1:0] s1_sh;
    logic                   s1_rm;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdy_q    <= 1'b0;
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls   <= CLS_ZERO;
            s1_mag   <= '0;
            s1_sh    <= '0;
            s1_rm    <= 1'b0;
        end else begin
            rdy_q    <= 1'b1;
            s1_valid <= in_fire | (s1_valid & !s1_advance);
            if (in_fire) begin
                s1_sign <= float_i[E_LEN+M_LEN];
                s1_cls  <= in_cls;
                s1_mag  <= {1'b1, in_man};
                s1_sh   <= in_sh;
                s1_rm   <= rm_i;
            end
        end
    end

    // stage 2: shift, round, saturate, negate
    int                 sh_i;
    int                 rs;
    logic               ovf_shift;
    logic               guard;
    logic               sticky;
    logic               inc;
    logic               big;
    logic [EXT_W-1:0]   ext_sh;
    logic [RW-1:0]      mag_t;
    logic [RW-1:0]      mag_r;

    always_comb begin
        sh_i      = int'(s1_sh);
        rs        = 0;
        ovf_shift = 1'b0;
        guard     = 1'b0;
        sticky    = 1'b0;
        ext_sh    = '0;
        mag_t     = '0;
        if (sh_i >= 0) begin
            if (sh_i + M_LEN > FIX_LEN - 1) begin
                ovf_shift = 1'b1;
            end else begin
                mag_t = RW'(s1_mag) << sh_i;
            end
        end else begin
            rs = -sh_i;
            // shifting past the guard position leaves only a sticky remainder
            if (rs > MAG_W) begin
                sticky = 1'b1;
            end else begin
                ext_sh = {s1_mag, {(MAG_W+1){1'b0}}} >> rs;
                mag_t  = RW'(ext_sh[EXT_W-1 -: MAG_W]);
                guard  = ext_sh[MAG_W];
                sticky = |ext_sh[MAG_W-1:0];
            end
        end
        inc   = s1_rm & guard & (sticky | mag_t[0]);
        mag_r = mag_t + RW'(inc);
        // negative side may reach exactly 2^(FIX_LEN-1)
        big   = ovf_shift | (s1_sign ? (mag_r > NEG_LIM) : (mag_r >= NEG_LIM));
    end

    logic [FIX_LEN-1:0] res_fix;
    logic [3:0]         res_flags;

    always_comb begin
        res_fix   = '0;
        res_flags = 4'b0000;
        case (s1_cls)
            CLS_NAN: begin
                res_fix   = MAX_POS;
                res_flags = 4'b1000;
            end
            CLS_INF: begin
                res_fix   = s1_sign ? MAX_NEG : MAX_POS;
                res_flags = 4'b1000;
            end
            CLS_ZERO: begin
                res_fix   = '0;
                res_flags = 4'b0000;
            end
            CLS_DENORM: begin
                res_flags = 4'b0011;
            end
            default: begin
                if (big) begin
                    res_fix   = s1_sign ? MAX_NEG : MAX_POS;
                    res_flags = 4'b0101;
                end else if (mag_r == '0) begin
                    res_flags = 4'b0011;
                end else begin
                    res_fix   = s1_sign ? (~mag_r[FIX_LEN-1:0] + FIX_LEN'(1))
                                        : mag_r[FIX_LEN-1:0];
                    res_flags = {3'b000, guard | sticky};
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            fix_o       <= '0;
            flags_o     <= 4'b0000;
        end else if (s1_advance) begin
            out_valid_o <= 1'b1;
            fix_o       <= res_fix;
            flags_o     <= res_flags;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule
